// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: frame codes shared with the transmit side, receiver FSM states and parity helper.
package uart_rx_pkg;

    localparam logic [1:0] CK_SPACE = 2'b00;
    localparam logic [1:0] CK_ODD   = 2'b01;
    localparam logic [1:0] CK_EVEN  = 2'b10;
    localparam logic [1:0] CK_MARK  = 2'b11;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    function automatic logic exp_parity(input logic [1:0] mode, input logic [7:0] d);
        return mode == CK_ODD ? ~^d : mode == CK_EVEN ? ^d : mode == CK_MARK;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer for the asynchronous rxd pin plus a falling-edge detect flop.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (rst) sh <= 3'b111;
        else     sh <= {sh[1:0], rxd};
    end

    assign rxd_s = sh[1];
    assign fall  = sh[2] & ~sh[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8x1 UART receiver, single mid-bit sample at count BPS_CNT/2-1.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around mid-bit; all pulses then move one cycle later.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int         BPS_CNT       = 100,
    parameter logic       CHECKSUM_EN   = 1'b0,
    parameter logic [1:0] CHECKSUM_MODE = CK_SPACE,
    parameter logic [1:0] STOP_BIT_W    = STOP_1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int            CW   = $clog2(BPS_CNT);
    localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] MID  = CW'(BPS_CNT / 2 - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rxd_s, fall, smp, smp_val, par_bad, stop_b, fin, good;

    always_comb assert (BPS_CNT >= 8 && STOP_BIT_W inside {STOP_1, STOP_1P5, STOP_2});

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rxd_s (rxd_s),
        .fall  (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote;

    always_ff @(posedge clk) begin
        if (rst) begin
            vote <= 2'b11;
        end else begin
            if (cnt == MID - 1'b1) vote[0] <= rxd_s;
            if (cnt == MID) vote[1] <= rxd_s;
        end
    end

    assign smp     = cnt == MID + 1'b1;
    assign smp_val = (vote[0] & vote[1]) | (rxd_s & (vote[0] | vote[1]));
`else
    assign smp     = cnt == MID;
    assign smp_val = rxd_s;
`endif

    // Bit timing restarts on the start edge so every sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= (state == ST_IDLE && fall) || cnt == LAST ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        state <= rst ? ST_IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (fall) state_nx = ST_START;
            ST_START:  if (smp) state_nx = smp_val ? ST_IDLE : ST_DATA;
            ST_DATA:   if (smp && bit_idx == 3'd7) state_nx = CHECKSUM_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (smp) state_nx = ST_STOP;
            ST_STOP:   if (smp) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= '0;
            shift   <= '0;
            par_bad <= 1'b0;
            stop_b  <= 1'b1;
            fin     <= 1'b0;
        end else begin
            fin <= state == ST_STOP && smp;
            if (state == ST_IDLE) begin
                bit_idx <= '0;
                par_bad <= 1'b0;
            end
            if (state == ST_DATA && smp) begin
                shift   <= {smp_val, shift[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == ST_PARITY && smp) par_bad <= smp_val != exp_parity(CHECKSUM_MODE, shift);
            if (state == ST_STOP && smp) stop_b <= smp_val;
        end
    end

    // Verdict lands one cycle after mid-stop, when the FSM is already back in IDLE.
    assign good = stop_b & ~par_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= fin & good;
            parity_err <= fin & par_bad;
            frame_err  <= fin & ~stop_b;
            if (fin && good) rx_data <= shift;
        end
    end

    assign rx_busy = state != ST_IDLE;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; dut0 is 8N1, dut1 has even parity and 2 stop bits.
module tb_uart_rx;

    localparam int BPS = 16;
    localparam int H   = BPS / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int LAT10 = 2 + 1 + 9 * BPS + H + 1 + MAJ;
    localparam int LAT11 = 2 + 1 + 10 * BPS + H + 1 + MAJ;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd0 = 1'b1, rxd1 = 1'b1;
    logic [7:0] d0, d1;
    logic       v0, v1, b0, b1, pe0, pe1, fe0, fe1;
    int         total = 0, bad = 0, cyc = 0;
    exp_t       q0[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.BPS_CNT(BPS)) dut0 (
        .clk(clk), .rst(rst), .rxd(rxd0), .rx_data(d0), .rx_valid(v0),
        .rx_busy(b0), .parity_err(pe0), .frame_err(fe0)
    );

    uart_rx #(.BPS_CNT(BPS), .CHECKSUM_EN(1'b1), .CHECKSUM_MODE(2'b10), .STOP_BIT_W(2'b10)) dut1 (
        .clk(clk), .rst(rst), .rxd(rxd1), .rx_data(d1), .rx_valid(v1),
        .rx_busy(b1), .parity_err(pe1), .frame_err(fe1)
    );

    // kind = {frame_err, parity_err, rx_valid}
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (v0 || pe0 || fe0)) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL sb0_unexpected got kind=%b data=%h at cyc=%0d, required no pulse", {fe0, pe0, v0}, d0, cyc);
            end else begin
                e = q0.pop_front();
                if ({fe0, pe0, v0} !== e.kind || (v0 && d0 !== e.data) || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL sb0 got kind=%b data=%h cyc=%0d, required kind=%b data=%h cyc=%0d",
                             {fe0, pe0, v0}, d0, cyc, e.kind, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (v1 || pe1 || fe1)) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL sb1_unexpected got kind=%b data=%h at cyc=%0d, required no pulse", {fe1, pe1, v1}, d1, cyc);
            end else begin
                e = q1.pop_front();
                if ({fe1, pe1, v1} !== e.kind || (v1 && d1 !== e.data) || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL sb1 got kind=%b data=%h cyc=%0d, required kind=%b data=%h cyc=%0d",
                             {fe1, pe1, v1}, d1, cyc, e.kind, e.data, e.cyc);
                end
            end
        end
    end

    task automatic drive(input bit sel, input logic b);
        if (sel) rxd1 = b;
        else     rxd0 = b;
    endtask

    // Called on a negedge; the start bit goes out immediately. half_stops counts stop time in half bits.
    task automatic send(input bit sel, input logic [7:0] d, input int par, input logic stop,
                        input int half_stops, input int spike);
        drive(sel, 1'b0);
        repeat (BPS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            if (i == spike) begin
                repeat (H) @(negedge clk);
                drive(sel, ~d[i]);
                @(negedge clk);
                drive(sel, d[i]);
                repeat (BPS - H - 1) @(negedge clk);
            end else begin
                repeat (BPS) @(negedge clk);
            end
        end
        if (par >= 0) begin
            drive(sel, par[0]);
            repeat (BPS) @(negedge clk);
        end
        drive(sel, stop);
        repeat (BPS) @(negedge clk);
        drive(sel, 1'b1);
        repeat ((half_stops - 2) * H) @(negedge clk);
    endtask

    task automatic wait_sb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 * BPS; i++) begin
            if (q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({d0, v0, b0, pe0, fe0} !== 12'h000) begin
            bad++;
            $display("FAIL reset_dut0 got %h, required 000", {d0, v0, b0, pe0, fe0});
        end
        total++;
        if ({d1, v1, b1, pe1, fe1} !== 12'h000) begin
            bad++;
            $display("FAIL reset_dut1 got %h, required 000", {d1, v1, b1, pe1, fe1});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({b0, b1, v0, v1} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle got %b, required 0000", {b0, b1, v0, v1});
        end
    endtask

    task automatic test_basic();
        bit ok;
        q0.push_back(exp_t'{3'b001, 8'hA5, cyc + LAT10});
        send(0, 8'hA5, -1, 1'b1, 2, -1);
        wait_sb(ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL basic_timeout got %0d pending, required 0", q0.size());
        end
        total++;
        if ({d0, b0} !== {8'hA5, 1'b0}) begin
            bad++;
            $display("FAIL basic_hold got data=%h busy=%b, required data=a5 busy=0", d0, b0);
        end
    endtask

    task automatic test_parity();
        bit ok;
        q1.push_back(exp_t'{3'b001, 8'h03, cyc + LAT11});
        send(1, 8'h03, 0, 1'b1, 4, -1);
        q1.push_back(exp_t'{3'b010, 8'h00, cyc + LAT11});
        send(1, 8'h03, 1, 1'b1, 4, -1);
        total++;
        if (d1 !== 8'h03) begin
            bad++;
            $display("FAIL parity_keep got %h, required 03", d1);
        end
        q1.push_back(exp_t'{3'b110, 8'h00, cyc + LAT11});
        send(1, 8'h81, 1, 1'b0, 4, -1);
        q1.push_back(exp_t'{3'b001, 8'h07, cyc + LAT11});
        send(1, 8'h07, 1, 1'b1, 4, -1);
        wait_sb(ok);
        total++;
        if (ok !== 1'b1 || d1 !== 8'h07) begin
            bad++;
            $display("FAIL parity_end got pending=%0d data=%h, required pending=0 data=07", q1.size(), d1);
        end
    endtask

    task automatic test_frame();
        bit ok;
        q0.push_back(exp_t'{3'b100, 8'h00, cyc + LAT10});
        send(0, 8'h55, -1, 1'b0, 2, -1);
        total++;
        if (d0 !== 8'hA5) begin
            bad++;
            $display("FAIL frame_keep got %h, required a5", d0);
        end
        repeat (2 * BPS) @(negedge clk);
        q0.push_back(exp_t'{3'b001, 8'h12, cyc + LAT10});
        send(0, 8'h12, -1, 1'b1, 2, -1);
        wait_sb(ok);
        total++;
        if (ok !== 1'b1 || d0 !== 8'h12) begin
            bad++;
            $display("FAIL frame_recover got pending=%0d data=%h, required pending=0 data=12", q0.size(), d0);
        end
    endtask

    task automatic test_glitch();
        rxd0 = 1'b0;
        repeat (4) @(negedge clk);
        rxd0 = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (b0 !== 1'b1) begin
            bad++;
            $display("FAIL glitch_busy got %b, required 1", b0);
        end
        repeat (BPS) @(negedge clk);
        total++;
        if ({b0, d0} !== {1'b0, 8'h12}) begin
            bad++;
            $display("FAIL glitch_idle got busy=%b data=%h, required busy=0 data=12", b0, d0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        q0.push_back(exp_t'{3'b001, 8'h00, cyc + LAT10});
        q0.push_back(exp_t'{3'b001, 8'hFF, cyc + 10 * BPS + LAT10});
        send(0, 8'h00, -1, 1'b1, 2, -1);
        send(0, 8'hFF, -1, 1'b1, 2, -1);
        q0.push_back(exp_t'{3'b001, 8'h00, cyc + LAT10});
        q0.push_back(exp_t'{3'b001, 8'hFF, cyc + 11 * BPS + LAT10});
        send(0, 8'h00, -1, 1'b1, 4, -1);
        send(0, 8'hFF, -1, 1'b1, 4, -1);
        wait_sb(ok);
        total++;
        if (ok !== 1'b1 || d0 !== 8'hFF) begin
            bad++;
            $display("FAIL b2b_end got pending=%0d data=%h, required pending=0 data=ff", q0.size(), d0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [9:0] fr;
        fr = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd0 = fr[i];
            if (i == 5) begin
                repeat (H) @(negedge clk);
                total++;
                if (b0 !== 1'b1) begin
                    bad++;
                    $display("FAIL rstmid_busy got %b, required 1", b0);
                end
                rst = 1'b1;
                @(negedge clk);
                total++;
                if ({d0, v0, b0, pe0, fe0} !== 12'h000) begin
                    bad++;
                    $display("FAIL rstmid_clear got %h, required 000", {d0, v0, b0, pe0, fe0});
                end
                repeat (BPS - H - 1) @(negedge clk);
            end else begin
                repeat (BPS) @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (BPS) @(negedge clk);
        q0.push_back(exp_t'{3'b001, 8'hC3, cyc + LAT10});
        send(0, 8'hC3, -1, 1'b1, 2, -1);
        wait_sb(ok);
        total++;
        if (ok !== 1'b1 || d0 !== 8'hC3) begin
            bad++;
            $display("FAIL rstmid_next got pending=%0d data=%h, required pending=0 data=c3", q0.size(), d0);
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_spike();
        bit ok;
        q0.push_back(exp_t'{3'b001, 8'hA5, cyc + LAT10});
        send(0, 8'hA5, -1, 1'b1, 2, 3);
        q0.push_back(exp_t'{3'b001, 8'h5A, cyc + LAT10});
        send(0, 8'h5A, -1, 1'b1, 2, 0);
        wait_sb(ok);
        total++;
        if (ok !== 1'b1 || d0 !== 8'h5A) begin
            bad++;
            $display("FAIL spike got pending=%0d data=%h, required pending=0 data=5a", q0.size(), d0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
        test_spike();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog at cyc=%0d, required test completion", cyc);
        $fatal(1);
    end

endmodule
